// File: rtl/adc_spi_pkg.sv
// Shared types and protocol constants for the MCP3002-class ADC reader.
// Frame layout: lead, start, sgl, odd/sign, msbf, null, then B9..B0.
package adc_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  localparam int FRAME_BITS     = 16;
  localparam int DATA_FIRST_BIT = 6;
  localparam int NULL_BIT       = 5;

  localparam logic START = 1'b1;
  localparam logic SGL   = 1'b1;
  localparam logic MSBF  = 1'b1;

  function automatic logic cmd_bit(
    input logic [3:0] k,
    input logic       ch
  );
    logic b;
    b = 1'b0;
    case (k)
      4'd1:    b = START;
      4'd2:    b = SGL;
      4'd3:    b = ch;
      4'd4:    b = MSBF;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/adc_sample_tick.sv
// Conversion-request timer: one-cycle req every SAMPLE_PERIOD clocks.
// Held at zero while sampling is disabled.
module adc_sample_tick
  import adc_spi_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic req
);

  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam logic [TW-1:0] LAST = TW'(SAMPLE_PERIOD - 1);

  logic [TW-1:0] timer;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
      req   <= 1'b0;
    end else begin
      req <= 1'b0;
      if (!enable) begin
        timer <= '0;
      end else if (timer == LAST) begin
        timer <= '0;
        req   <= 1'b1;
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// SPI mode-0 master reading a 10-bit ADC; emits adc_measure
// with a one-cycle sample_valid at the end of each frame.
module adc_spi_reader
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       channel,
  input  logic       miso,
  output logic       cs_n,
  output logic       sclk,
  output logic       mosi,
  output logic [9:0] adc_measure,
  output logic       sample_valid,
  output logic       busy
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [3:0] K_LAST = 4'(FRAME_BITS - 1);
  localparam logic [3:0] K_DATA = 4'(DATA_FIRST_BIT);

  state_t        state;
  logic [DW-1:0] div;
  logic          div_end;
  logic [3:0]    k;
  logic          high;
  logic          ch_q;
  logic [9:0]    shreg;
  logic          miso_m;
  logic          miso_s;
  logic          req;

  assign div_end = (div == DIV_LAST);

  adc_sample_tick #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .req   (req)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miso_m <= 1'b0;
      miso_s <= 1'b0;
    end else begin
      miso_m <= miso;
      miso_s <= miso_m;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      div          <= '0;
      k            <= '0;
      high         <= 1'b0;
      ch_q         <= 1'b0;
      shreg        <= '0;
      cs_n         <= 1'b1;
      sclk         <= 1'b0;
      mosi         <= 1'b0;
      adc_measure  <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      div <= div_end ? '0 : div + DW'(1);
      unique case (state)
        IDLE: begin
          div <= '0;
          if (req) begin
            ch_q  <= channel;
            k     <= '0;
            high  <= 1'b0;
            shreg <= '0;
            busy  <= 1'b1;
            cs_n  <= 1'b0;
            mosi  <= cmd_bit(4'd0, channel);
            state <= SETUP;
          end
        end
        SETUP: begin
          if (div_end) state <= SHIFT;
        end
        SHIFT: begin
          if (div_end) begin
            if (!high) begin
              high <= 1'b1;
              sclk <= 1'b1;
            end else begin
              high <= 1'b0;
              sclk <= 1'b0;
              // B9..B0 arrive on k=6..15; the null bit is skipped
              if (k >= K_DATA)
                shreg <= {shreg[8:0], miso_s};
              if (k == K_LAST) begin
                adc_measure  <= {shreg[8:0], miso_s};
                sample_valid <= 1'b1;
                cs_n         <= 1'b1;
                mosi         <= 1'b0;
                state        <= HOLD;
              end else begin
                k    <= k + 4'd1;
                mosi <= cmd_bit(k + 4'd1, ch_q);
              end
            end
          end
        end
        HOLD: begin
          if (div_end) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Scoreboard bench for adc_spi_reader with a behavioural ADC model.
// Small divider/period so whole frames fit in a short run.
module tb_adc_spi_reader;

  localparam int CD = 4;
  localparam int SP = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic       channel = 1'b0;
  logic       miso = 1'b0;
  logic       cs_n;
  logic       sclk;
  logic       mosi;
  logic [9:0] adc_measure;
  logic       sample_valid;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [9:0] data_q[$];
  logic [9:0] exp_q[$];
  int         fall_cyc[$];
  logic       ch_bits[$];

  int         rise_cnt = 0;
  int         low_cnt = 0;
  int         valid_cnt = 0;
  logic [15:0] mosi_bits = '0;
  logic       glitch = 1'b0;
  logic       exp_ch = 1'b0;
  logic       in_frame = 1'b0;
  logic       prev_cs = 1'b1;
  logic       prev_sclk = 1'b0;
  logic       prev_mosi = 1'b0;
  logic       prev_valid = 1'b0;
  logic [9:0] last_meas = '0;
  logic [9:0] sb_e;

  logic [9:0] cur = '0;
  int         mk = 0;
  logic       m_prev_cs = 1'b1;
  logic       m_prev_sclk = 1'b0;

  adc_spi_reader #(
    .CLK_DIV      (CD),
    .SAMPLE_PERIOD(SP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .channel     (channel),
    .miso        (miso),
    .cs_n        (cs_n),
    .sclk        (sclk),
    .mosi        (mosi),
    .adc_measure (adc_measure),
    .sample_valid(sample_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic bit_for(input logic [9:0] d, input int j);
    if (j >= 6 && j <= 15) return d[15 - j];
    return 1'b0;
  endfunction

  // ADC model: new bit on each sclk fall, index = rises so far
  always @(negedge clk) begin
    if (cs_n) begin
      miso = 1'($urandom);
    end else if (m_prev_cs) begin
      if (data_q.size() != 0) cur = data_q.pop_front();
      else cur = '0;
      exp_q.push_back(cur);
      mk = 0;
      miso = 1'b0;
    end else begin
      if (m_prev_sclk && !sclk) miso = bit_for(cur, mk);
      if (!m_prev_sclk && sclk) mk++;
    end
    m_prev_cs = cs_n;
    m_prev_sclk = sclk;
  end

  always @(negedge clk) begin
    if (!rst) begin
      in_frame = 1'b0;
      prev_cs = 1'b1;
      prev_sclk = 1'b0;
      prev_mosi = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_cs && !cs_n) begin
        in_frame = 1'b1;
        low_cnt = 0;
        rise_cnt = 0;
        glitch = 1'b0;
        mosi_bits = '0;
        exp_ch = channel;
        fall_cyc.push_back(cyc);
        chk("busy", busy, 1);
        chk("hold_meas", adc_measure, last_meas);
      end
      if (!cs_n) low_cnt++;
      if (!prev_sclk && sclk) begin
        if (rise_cnt < 16) mosi_bits[rise_cnt] = mosi;
        rise_cnt++;
      end
      if (prev_sclk && sclk && mosi !== prev_mosi) glitch = 1'b1;
      if (in_frame && !prev_cs && cs_n) begin
        in_frame = 1'b0;
        chk("cs_low", low_cnt, 33 * CD);
        chk("sclk_rises", rise_cnt, 16);
        chk("mosi_cmd", mosi_bits,
            {11'b0, 1'b1, exp_ch, 2'b11, 1'b0});
        chk("mosi_stable", glitch, 0);
        ch_bits.push_back(mosi_bits[3]);
      end
      if (sample_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          chk("sb_empty", exp_q.size(), 1);
        end else begin
          sb_e = exp_q.pop_front();
          chk("adc_measure", adc_measure, sb_e);
          last_meas = sb_e;
        end
      end
      if (prev_valid) chk("valid_pulse", sample_valid, 0);
      prev_cs = cs_n;
      prev_sclk = sclk;
      prev_mosi = mosi;
      prev_valid = sample_valid;
    end
  end

  task automatic wait_valid(input int target);
    int i;
    i = 0;
    while (valid_cnt < target && i < 3000) begin
      @(negedge clk);
      i++;
    end
    chk("valid_timeout", valid_cnt >= target, 1);
  endtask

  task automatic wait_bit(input int frame, input int rises);
    int i;
    i = 0;
    while ((fall_cyc.size() < frame || rise_cnt < rises)
           && i < 3000) begin
      @(negedge clk);
      i++;
    end
    chk("bit_timeout", rise_cnt >= rises, 1);
  endtask

  task automatic cs_fall_latency(input string tag);
    int n;
    n = 0;
    while (cs_n && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, n, SP + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n0;
    data_q = '{10'h2A5, 10'h000, 10'h3FF, 10'h200, 10'h155,
               10'h0AA, 10'h3C3, 10'h1F0, 10'h2C7};

    repeat (10) begin
      @(negedge clk);
      chk("rst_outs",
          {cs_n, sclk, mosi, sample_valid, busy, adc_measure},
          {5'b10000, 10'h000});
    end
    @(posedge clk);
    #1 rst = 1'b1;

    wait_valid(4);
    for (int i = 1; i < 4; i++)
      chk("spacing", fall_cyc[i] - fall_cyc[i-1], SP);

    wait_bit(5, 9);
    channel = 1'b1;
    wait_valid(6);
    chk("ch_cur", ch_bits[4], 0);
    chk("ch_next", ch_bits[5], 1);

    wait_bit(7, 11);
    enable = 1'b0;
    wait_valid(7);
    n0 = fall_cyc.size();
    repeat (1000) @(negedge clk);
    chk("no_frame", fall_cyc.size(), n0);

    @(posedge clk);
    #1 enable = 1'b1;
    cs_fall_latency("reenable_lat");

    wait_bit(8, 9);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rst_async", {cs_n, sclk}, 2'b10);
    exp_q.delete();
    last_meas = '0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_meas", {sample_valid, adc_measure}, 11'h000);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    cs_fall_latency("rst_restart");
    wait_valid(8);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
